fifo_rd_stream: RTL and testbench

FIFO_RD_STREAM -- requirements
Module: fifo_rd_stream

---
 rtl/afifo_pkg.sv | 15 +
 rtl/rd_skid_buf.sv | 68 ++++++
 rtl/fifo_rd_stream.sv | 78 +++++++
 tb/tb_fifo_rd_stream.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/afifo_pkg.sv
// Shared async-FIFO types: word type, depth and the read-stream FSM states.
// Imported by the read-side streaming front end and its output buffer.
package afifo_pkg;

  localparam int DEPTH = 16;

  typedef logic [7:0] data_ty;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    STOP = 2'd2
  } rd_state_ty;

endpackage

// File: rtl/rd_skid_buf.sv
// Two-entry in-order output buffer between the FIFO read port and the stream.
// A write and a pop may coincide; the head entry always drives the stream.
module rd_skid_buf #(
  parameter int DATA_W = 8
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              wr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic              pop_i,
  output logic [1:0]        occ_o,
  output logic [DATA_W-1:0] head_o
);

  logic [1:0]        occ_q, occ_d;
  logic [DATA_W-1:0] s0_q, s0_d;
  logic [DATA_W-1:0] s1_q, s1_d;

  always_comb begin
    occ_d = occ_q;
    s0_d  = s0_q;
    s1_d  = s1_q;
    unique case ({wr_i, pop_i})
      2'b10: begin
        if (occ_q == 2'd0) s0_d = wdata_i;
        else               s1_d = wdata_i;
        occ_d = occ_q + 2'd1;
      end
      2'b01: begin
        s0_d  = s1_q;
        occ_d = occ_q - 2'd1;
      end
      2'b11: begin
        // Head leaves while the new word lands behind any survivor.
        if (occ_q == 2'd1) begin
          s0_d = wdata_i;
        end else begin
          s0_d = s1_q;
          s1_d = wdata_i;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      occ_q <= 2'd0;
      s0_q  <= '0;
      s1_q  <= '0;
    end else begin
      occ_q <= occ_d;
      s0_q  <= s0_d;
      s1_q  <= s1_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      assert (!(wr_i && !pop_i && occ_q == 2'd2));
      assert (!(pop_i && occ_q == 2'd0));
    end
  end

  assign occ_o  = occ_q;
  assign head_o = s0_q;

endmodule

// File: rtl/fifo_rd_stream.sv
// Pops a FIFO read port and presents the words as a valid/ready stream.
// Pops are throttled so the two-entry buffer can never overflow.
module fifo_rd_stream
  import afifo_pkg::*;
#(
  parameter int DATA_W = $bits(data_ty),
  parameter int CNT_W  = 16
) (
  input  logic              rd_clk,
  input  logic              rd_rst,
  input  logic              enable,
  input  logic              fifo_empty,
  output logic              fifo_rd_en,
  input  logic [DATA_W-1:0] fifo_data,
  output logic              m_valid,
  output logic [DATA_W-1:0] m_data,
  input  logic              m_ready,
  output logic              busy,
  output logic [CNT_W-1:0]  pop_cnt
);

  rd_state_ty       state_q, state_d;
  logic             inflight_q;
  logic [CNT_W-1:0] cnt_q;
  logic [1:0]       occ;
  logic             xfer;
  logic [2:0]       load;

  rd_skid_buf #(
    .DATA_W (DATA_W)
  ) u_buf (
    .clk_i   (rd_clk),
    .rst_i   (rd_rst),
    .wr_i    (inflight_q),
    .wdata_i (fifo_data),
    .pop_i   (xfer),
    .occ_o   (occ),
    .head_o  (m_data)
  );

  assign m_valid = (occ != 2'd0);
  assign xfer    = m_valid && m_ready;

  // Words held or arriving after this edge; a pop is safe below two.
  assign load = {1'b0, occ} + {2'b0, inflight_q} - {2'b0, xfer};

  assign fifo_rd_en = !rd_rst && (state_q == RUN) &&
                      !fifo_empty && (load < 3'd2);

  assign busy    = (state_q != IDLE) || (occ != 2'd0);
  assign pop_cnt = cnt_q;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (enable) state_d = RUN;
      RUN:  if (!enable) state_d = STOP;
      STOP: begin
        if (enable)           state_d = RUN;
        else if (!inflight_q) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge rd_clk) begin
    if (rd_rst) begin
      state_q    <= IDLE;
      inflight_q <= 1'b0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      inflight_q <= fifo_rd_en;
      if (xfer) cnt_q <= cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Bench for fifo_rd_stream: queue-based reference model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_fifo_rd_stream;

  localparam int S_IDLE = 0;
  localparam int S_RUN  = 1;
  localparam int S_STOP = 2;

  logic        rd_clk = 1'b0;
  logic        rd_rst;
  logic        enable;
  logic        fifo_empty;
  logic        fifo_rd_en;
  logic [7:0]  fifo_data;
  logic        m_valid;
  logic [7:0]  m_data;
  logic        m_ready;
  logic        busy;
  logic [15:0] pop_cnt;

  fifo_rd_stream #(.DATA_W(8), .CNT_W(16)) dut (
    .rd_clk     (rd_clk),
    .rd_rst     (rd_rst),
    .enable     (enable),
    .fifo_empty (fifo_empty),
    .fifo_rd_en (fifo_rd_en),
    .fifo_data  (fifo_data),
    .m_valid    (m_valid),
    .m_data     (m_data),
    .m_ready    (m_ready),
    .busy       (busy),
    .pop_cnt    (pop_cnt)
  );

  always #5 rd_clk = ~rd_clk;

  int checks = 0;
  int failures = 0;

  logic [7:0]  fifoq[$];
  logic [7:0]  mbuf[$];
  int          mst = S_IDLE;
  bit          minf = 0;
  logic [7:0]  minf_w = 8'h00;
  logic [15:0] mcnt = 16'h0;
  bit          mok = 0;
  bit          force_e = 0;

  logic        o_rd, o_valid, o_busy;
  logic [7:0]  o_data;
  logic [15:0] o_cnt;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  // One cycle: drive, compare against the model, advance the model.
  task automatic step();
    bit xf, erd, ev;
    int ld, nst;
    fifo_empty = (fifoq.size() == 0) || force_e;
    #1;
    o_rd = fifo_rd_en; o_valid = m_valid; o_data = m_data;
    o_busy = busy; o_cnt = pop_cnt;
    ev  = (mbuf.size() > 0);
    xf  = ev && m_ready;
    ld  = mbuf.size() + int'(minf) - int'(xf);
    erd = !rd_rst && (mst == S_RUN) && !fifo_empty && (ld < 2);
    chk("rd_en", o_rd, erd);
    if (mok) begin
      chk("m_valid", o_valid, ev);
      if (ev) chk("m_data", o_data, mbuf[0]);
      chk("busy", o_busy, (mst != S_IDLE) || ev);
      chk("pop_cnt", o_cnt, mcnt);
    end
    @(posedge rd_clk);
    if (rd_rst) begin
      mst = S_IDLE; minf = 0; mbuf.delete(); mcnt = 16'h0; mok = 1;
    end else begin
      nst = mst;
      if (mst == S_IDLE && enable) nst = S_RUN;
      else if (mst == S_RUN && !enable) nst = S_STOP;
      else if (mst == S_STOP) begin
        if (enable) nst = S_RUN;
        else if (!minf) nst = S_IDLE;
      end
      if (xf) begin
        void'(mbuf.pop_front());
        mcnt++;
      end
      if (minf) mbuf.push_back(minf_w);
      minf = erd;
      if (erd) minf_w = fifoq.pop_front();
      mst = nst;
    end
    #1;
    if (erd) fifo_data = minf_w;
    else     fifo_data = 8'($urandom);
    @(negedge rd_clk);
  endtask

  task automatic drain();
    int n;
    enable = 0; m_ready = 1; force_e = 0; n = 0;
    do begin
      step(); n++;
    end while (o_busy && n < 60);
    chk("drain_done", o_busy, 1'b0);
    fifoq.delete();
  endtask

  initial begin
    int first_rd, first_v, last_v, nv, bad, pops, xfers, n;
    rd_rst = 1; enable = 1; m_ready = 1; fifo_data = 8'h00;
    for (int i = 0; i < 8; i++) fifoq.push_back(8'(i + 8'hA0));
    @(negedge rd_clk);

    // Reset held with enable and a non-empty FIFO.
    for (int i = 0; i < 4; i++) begin
      step();
      chk("rst_rd_en", o_rd, 1'b0);
      if (i > 0) begin
        chk("rst_valid", o_valid, 1'b0);
        chk("rst_cnt", o_cnt, 16'h0);
        chk("rst_data", o_data, 8'h00);
        chk("rst_busy", o_busy, 1'b0);
      end
    end
    rd_rst = 0; enable = 0; fifoq.delete();
    step();

    // 16 words streamed back to back.
    for (int i = 1; i <= 16; i++) fifoq.push_back(8'(i));
    enable = 1; m_ready = 1;
    first_rd = -1; first_v = -1; last_v = -1; nv = 0; bad = 0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (o_rd && first_rd < 0) first_rd = i;
      if (o_valid) begin
        if (first_v < 0) first_v = i;
        last_v = i;
        if (o_data != 8'(nv + 1)) bad++;
        nv++;
      end
    end
    chk("t31_words", nv, 16);
    chk("t31_latency", first_v - first_rd, 2);
    chk("t31_no_gap", last_v - first_v, 15);
    chk("t31_order_err", bad, 0);
    chk("t31_pop_cnt", o_cnt, 16'd16);
    drain();

    // Stalled sink with a full FIFO.
    for (int i = 1; i <= 16; i++) fifoq.push_back(8'(i));
    enable = 1; m_ready = 0; pops = 0;
    for (int i = 0; i < 12; i++) begin
      step();
      if (o_rd) pops++;
    end
    chk("t32_pops", pops, 2);
    chk("t32_hold_valid", o_valid, 1'b1);
    chk("t32_hold_data", o_data, 8'h01);
    m_ready = 1;
    for (int k = 1; k <= 3; k++) begin
      step();
      chk("t32_valid", o_valid, 1'b1);
      chk("t32_data", o_data, 8'(k));
    end
    drain();

    // Enable withdrawn right after a pop.
    for (int i = 0; i < 4; i++) fifoq.push_back(8'(8'h50 + i));
    enable = 1; m_ready = 1; pops = 0; xfers = 0; n = 0;
    do begin
      step(); n++;
    end while (!o_rd && n < 10);
    chk("t33_got_pop", o_rd, 1'b1);
    pops = 1;
    enable = 0;
    step();
    if (o_rd) pops++;
    if (o_valid) xfers++;
    bad = 0;
    for (int i = 0; i < 12; i++) begin
      step();
      if (o_rd) bad++;
      if (o_valid) xfers++;
    end
    chk("t33_late_pops", bad, 0);
    chk("t33_delivered", xfers, pops);
    chk("t33_busy_low", o_busy, 1'b0);
    fifoq.delete();

    // RUN with an empty FIFO.
    enable = 1; m_ready = 1; bad = 0; nv = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (o_rd) bad++;
      if (o_valid) nv++;
    end
    chk("t34_rd_en", bad, 0);
    chk("t34_valid", nv, 0);
    drain();

    // Randomised traffic, including resets mid-stream.
    for (int i = 0; i < 3000; i++) begin
      rd_rst  = ($urandom_range(0, 399) == 0);
      if ($urandom_range(0, 9) == 0) enable = !enable;
      m_ready = ($urandom_range(0, 9) < 7);
      force_e = ($urandom_range(0, 9) < 2);
      if (fifoq.size() < 16 && $urandom_range(0, 2) != 0)
        fifoq.push_back(8'($urandom));
      step();
    end
    rd_rst = 0; force_e = 0;
    drain();

    // Counter wrap at 0xFFFF.
    rd_rst = 1; step(); rd_rst = 0;
    enable = 1; m_ready = 1; n = 0;
    while (mcnt != 16'hFFFF && n < 70000) begin
      while (fifoq.size() < 8) fifoq.push_back(8'($urandom));
      step(); n++;
    end
    chk("t35_reached", mcnt, 16'hFFFF);
    m_ready = 0; enable = 0;
    step();
    chk("t35_cnt_max", o_cnt, 16'hFFFF);
    chk("t35_valid", o_valid, 1'b1);
    m_ready = 1;
    step();
    step();
    chk("t35_cnt_wrap", o_cnt, 16'h0000);
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
